// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between instruction fetch and the LSU.
// Latency: request sampled in IDLE, N byte cycles (N=1/2/4), ack one cycle later.
// Backpressure: requesters hold req until ack; requests are ignored while busy.
module mem_port_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic [31:0] fetch_rdata,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ack,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t      state;
  logic        grant_lsu;   // requester currently being served (1 = LSU)
  logic        last_lsu;    // requester served last (1 = LSU), used for round-robin
  logic [31:0] base;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;        // fetch is latched as an unsigned word access
  logic        we_q;
  logic [1:0]  cnt;
  logic [31:0] buf_q;
  logic        mem_we_q;

  logic        pick_lsu;
  logic [1:0]  last_idx;
  logic [1:0]  nxt;
  logic [31:0] asm_word;
  logic [31:0] ext;
  logic [7:0]  next_byte;

  // Arbitration: LSU fixed priority or round-robin on a tie.
  always_comb begin
    pick_lsu = lsu_req;
    if (lsu_req && fetch_req) begin
      pick_lsu = (ARB_MODE == 0) ? 1'b1 : ~last_lsu;
    end
  end

  // Byte bookkeeping: last byte index, next store byte, word assembled with the current read byte.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
    nxt = cnt + 2'd1;
    next_byte = wdata_q[{nxt, 3'b000} +: 8];
    asm_word = buf_q;
    asm_word[{cnt, 3'b000} +: 8] = mem_rdata;
  end

  // Sign or zero extension of sub-word loads.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   ext = {{24{~f3_q[2] & asm_word[7]}}, asm_word[7:0]};
      2'b01:   ext = {{16{~f3_q[2] & asm_word[15]}}, asm_word[15:0]};
      default: ext = asm_word;
    endcase
  end

  // Reset aborts a store immediately, so the byte in flight is not written.
  assign mem_we = mem_we_q & ~rst;
  assign busy   = (state != IDLE);

  // Main FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_lsu   <= 1'b0;
      last_lsu    <= 1'b0;
      base        <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      cnt         <= '0;
      buf_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fetch_ack   <= 1'b0;
      fetch_rdata <= '0;
      lsu_ack     <= 1'b0;
      lsu_rdata   <= '0;
      lsu_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req || lsu_req) begin
            grant_lsu <= pick_lsu;
            cnt       <= '0;
            buf_q     <= '0;
            if (pick_lsu) begin
              base    <= lsu_addr;
              we_q    <= lsu_we;
              f3_q    <= lsu_funct3;
              wdata_q <= lsu_wdata;
              if (lsu_funct3[1:0] == 2'b11) begin
                // Reserved width: answer with an error and never touch memory.
                state     <= ACK;
                lsu_ack   <= 1'b1;
                lsu_err   <= 1'b1;
                lsu_rdata <= '0;
              end else begin
                state     <= XFER;
                mem_addr  <= lsu_addr;
                mem_we_q  <= lsu_we;
                mem_wdata <= lsu_we ? lsu_wdata[7:0] : 8'h00;
              end
            end else begin
              base      <= fetch_addr;
              we_q      <= 1'b0;
              f3_q      <= 3'b110;
              wdata_q   <= '0;
              state     <= XFER;
              mem_addr  <= fetch_addr;
              mem_we_q  <= 1'b0;
              mem_wdata <= 8'h00;
            end
          end
        end
        XFER: begin
          if (!we_q) begin
            buf_q <= asm_word;
          end
          if (cnt == last_idx) begin
            state     <= ACK;
            mem_addr  <= '0;
            mem_we_q  <= 1'b0;
            mem_wdata <= 8'h00;
            if (grant_lsu) begin
              lsu_ack   <= 1'b1;
              lsu_err   <= 1'b0;
              lsu_rdata <= we_q ? 32'h0 : ext;
            end else begin
              fetch_ack   <= 1'b1;
              fetch_rdata <= asm_word;
            end
          end else begin
            cnt       <= nxt;
            mem_addr  <= base + {30'b0, nxt};
            mem_wdata <= we_q ? next_byte : 8'h00;
          end
        end
        ACK: begin
          fetch_ack <= 1'b0;
          lsu_ack   <= 1'b0;
          lsu_err   <= 1'b0;
          last_lsu  <= grant_lsu;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table vectors, random traffic against a byte-level model,
// plus tie-break and reset-abort sequences. Round-robin instance is the main DUT.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = '0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;

  logic        fetch_ack, lsu_ack, lsu_err, mem_we, busy;
  logic [31:0] fetch_rdata, lsu_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        fetch_ack0, lsu_ack0, lsu_err0, mem_we0, busy0;
  logic [31:0] fetch_rdata0, lsu_rdata0, mem_addr0;
  logic [7:0]  mem_wdata0, mem_rdata0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  ref_mem [0:4095];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_fetch = '0;
  logic [31:0] last_lsu = '0;
  bit          lsu_hold_valid = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ARB_MODE(1)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_port_arbiter #(.ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack0), .fetch_rdata(fetch_rdata0),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_ack(lsu_ack0), .lsu_rdata(lsu_rdata0), .lsu_err(lsu_err0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .busy(busy0)
  );

  // 4 KiB byte memory aliased over the address space; only the main DUT writes it.
  assign mem_rdata  = mem[mem_addr[11:0]];
  assign mem_rdata0 = mem[mem_addr0[11:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:0]] = mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: bytes per access and extended load value from the shadow memory.
  function automatic int nbytes(input bit is_f, input logic [2:0] f3);
    if (is_f) return 4;
    case (f3[1:0])
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input bit is_f, input logic [2:0] f3, input logic [31:0] addr);
    longint v = 0;
    int n = nbytes(is_f, f3);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      v = v + (longint'(ref_mem[a[11:0]]) << (8 * i));
    end
    if (!is_f && !f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic run_txn(input bit is_f, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit use_tab, input logic [31:0] tab_exp,
                         input string name);
    int n = nbytes(is_f, f3);
    bit err = (n == 0);
    bit is_st = !is_f && we && !err;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic [31:0] got_rd = '0;
    logic        got_err = 1'b0;
    bit seq_ok = 1'b1;
    bit other_ack = 1'b0;
    int ack_cyc = 0;
    exp_rd = is_st ? 32'h0 : model_load(is_f, f3, addr);
    if (use_tab) exp_rd = tab_exp;
    @(negedge clk);
    if (is_f) begin
      fetch_req = 1'b1; fetch_addr = addr;
    end else begin
      lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    end
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j <= n) begin
        a = addr + (j - 1);
        if (mem_addr !== a || mem_we !== is_st) seq_ok = 1'b0;
        if (is_st && mem_wdata !== 8'((wd >> (8 * (j - 1))) & 32'hFF)) seq_ok = 1'b0;
      end else if (mem_we !== 1'b0) seq_ok = 1'b0;
      if ((is_f ? lsu_ack : fetch_ack) === 1'b1) other_ack = 1'b1;
      if ((is_f ? fetch_ack : lsu_ack) === 1'b1) begin
        ack_cyc = j;
        got_rd  = is_f ? fetch_rdata : lsu_rdata;
        got_err = lsu_err;
        break;
      end
    end
    fetch_req = 1'b0; lsu_req = 1'b0;
    chk({name, " ack_cycle"}, ack_cyc, err ? 1 : n + 1);
    chk({name, " byte_seq"}, {31'b0, seq_ok}, 32'd1);
    chk({name, " err"}, {31'b0, got_err}, {31'b0, err});
    chk({name, " other_ack"}, {31'b0, other_ack}, 32'd0);
    if (!err) chk({name, " rdata"}, got_rd, exp_rd);
    if (is_f) begin
      if (lsu_hold_valid) chk({name, " lsu_rdata_hold"}, lsu_rdata, last_lsu);
      last_fetch = exp_rd;
    end else begin
      chk({name, " fetch_rdata_hold"}, fetch_rdata, last_fetch);
      last_lsu = exp_rd;
      lsu_hold_valid = !err;
    end
    @(negedge clk);
    chk({name, " idle_after"}, {busy, mem_we, 30'b0}, 32'd0);
    chk({name, " addr_idle"}, mem_addr, 32'd0);
    if (is_st) begin
      for (int i = 0; i < n; i++) begin
        a = addr + i;
        ref_mem[a[11:0]] = 8'((wd >> (8 * i)) & 32'hFF);
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    last_fetch = '0; last_lsu = '0; lsu_hold_valid = 1'b1;
  endtask

  typedef struct {
    bit          is_f;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tab [7];

  initial begin
    logic [7:0] b;
    int ev1_kind [3];
    int ev1_cyc [3];
    int n1, n0, f0cnt, first0_kind, first0_cyc;
    logic [31:0] f_exp, l_exp, f_got, ra;
    logic [2:0] rf3;

    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      mem[i] = b; ref_mem[i] = b;
    end
    mem[12'hAEF] = 8'h93; mem[12'hAF0] = 8'h02; mem[12'hAF1] = 8'hB0; mem[12'hAF2] = 8'h07;
    mem[12'h080] = 8'h88;
    mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22; mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    tab[0] = '{1'b1, 1'b0, 3'b010, 32'h0000_0AEF, 32'h0, 32'h07B0_0293};
    tab[1] = '{1'b0, 1'b0, 3'b000, 32'h0000_0080, 32'h0, 32'hFFFF_FF88};
    tab[2] = '{1'b0, 1'b0, 3'b100, 32'h0000_0080, 32'h0, 32'h0000_0088};
    tab[3] = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    tab[4] = '{1'b0, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'hFFFF_DEAD};
    tab[5] = '{1'b0, 1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0};
    tab[6] = '{1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h4433_2211};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset acks", {29'b0, fetch_ack, lsu_ack, lsu_err}, 32'd0);
    chk("reset mem_port", {mem_addr[31:9], mem_we, mem_wdata}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset fetch_rdata", fetch_rdata, 32'd0);
    chk("reset lsu_rdata", lsu_rdata, 32'd0);

    for (int i = 0; i < 7; i++)
      run_txn(tab[i].is_f, tab[i].we, tab[i].f3, tab[i].addr, tab[i].wd, 1'b1, tab[i].exp,
              $sformatf("vec%0d", i));
    chk("store bytes 0x100", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEAD_BEEF);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      rf3 = 3'($urandom_range(0, 7));
      run_txn($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rf3, ra, $urandom, 1'b0, 32'h0,
              $sformatf("rnd%0d", i));
    end

    // Tie: both requests held continuously from reset.
    reset_pulse();
    l_exp = model_load(1'b0, 3'b010, 32'h300);
    f_exp = model_load(1'b1, 3'b010, 32'h400);
    f_got = '0;
    n1 = 0; n0 = 0; f0cnt = 0; first0_kind = 0; first0_cyc = 0;
    for (int k = 0; k < 3; k++) begin ev1_kind[k] = 0; ev1_cyc[k] = 0; end
    fetch_req = 1'b1; fetch_addr = 32'h400;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h300; lsu_wdata = '0;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if ((lsu_ack || fetch_ack) && n1 < 3) begin
        ev1_kind[n1] = lsu_ack ? 1 : 2; ev1_cyc[n1] = j; n1++;
        if (fetch_ack) f_got = fetch_rdata;
        if (lsu_ack) chk("tie rr lsu_rdata", lsu_rdata, l_exp);
      end
      if (fetch_ack0) f0cnt++;
      if ((lsu_ack0 || fetch_ack0) && n0 == 0) begin
        first0_kind = lsu_ack0 ? 1 : 2; first0_cyc = j; n0++;
      end
    end
    fetch_req = 1'b0; lsu_req = 1'b0;
    chk("tie rr ev0", {ev1_kind[0][15:0], ev1_cyc[0][15:0]}, {16'd1, 16'd5});
    chk("tie rr ev1", {ev1_kind[1][15:0], ev1_cyc[1][15:0]}, {16'd2, 16'd11});
    chk("tie rr ev2", {ev1_kind[2][15:0], ev1_cyc[2][15:0]}, {16'd1, 16'd17});
    chk("tie rr fetch_rdata", f_got, f_exp);
    chk("tie fixed first", {first0_kind[15:0], first0_cyc[15:0]}, {16'd1, 16'd5});
    chk("tie fixed no fetch", f0cnt, 0);

    // Reset during the second byte of a word store.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin mem[12'h200 + i] = 8'h00; ref_mem[12'h200 + i] = 8'h00; end
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h200; lsu_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("abort cnt0", {mem_addr[15:0], 7'b0, mem_we, mem_wdata}, {16'h0200, 8'h01, 8'h44});
    @(negedge clk);
    chk("abort cnt1", {mem_addr[15:0], 7'b0, mem_we, mem_wdata}, {16'h0201, 8'h01, 8'h33});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lsu_req = 1'b0;
    chk("abort idle", {29'b0, busy, mem_we, lsu_ack}, 32'd0);
    @(negedge clk);
    chk("abort no ack", {30'b0, busy, lsu_ack}, 32'd0);
    chk("abort mem", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}, 32'h0000_0044);
    ref_mem[12'h200] = 8'h44;
    last_fetch = '0; last_lsu = '0; lsu_hold_valid = 1'b1;
    run_txn(1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 32'h0000_0044, "post_abort lw");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
